// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the memory responder.
//   state_e   : responder FSM states (idle, wait states, response)
//   MMIO_*    : word offsets of the I/O registers above MMIO_BASE
//   LED_W/SW_W: width of the LED register and the switch input
//   CYC_W     : width of the free-running cycle counter
//   CNT_W     : width of the wait-state counter (WAIT_CYCLES 0..15)
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MMIO_LED = 0;
  localparam int unsigned MMIO_SW  = 1;
  localparam int unsigned MMIO_CYC = 2;

  localparam int LED_W = 10;
  localparam int SW_W  = 10;
  localparam int CYC_W = 16;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port synchronous RAM, 2^ADDR_W x DATA_W.
//   clk   : rising-edge clock
//   we    : write enable (caller restricts it to RAM addresses)
//   addr  : word address, used for both read and write
//   wdata : write data
//   rdata : registered read data (read-before-write on a shared address)
// Contents are deliberately not reset.
module mem_resp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time memory responder with programmable wait
// states, backing a RAM below MMIO_BASE and an I/O window above it.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/we/addr/wdata, req_ready : request handshake (accept in IDLE)
//   rsp_valid/rdata/err : one-cycle response, WAIT_CYCLES+1 cycles after accept
//   sw_in               : asynchronous switches, two-flop synchronized
//   led_out             : LED register
// MMIO map relative to MMIO_BASE: +0 LED (rw), +1 switches (ro),
// +2 cycle counter (ro), rest unmapped (reads 0, errors).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter int unsigned MMIO_BASE   = 'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(MMIO_BASE);
  localparam logic [ADDR_W-1:0] A_LED  = ADDR_W'(MMIO_BASE + MMIO_LED);
  localparam logic [ADDR_W-1:0] A_SW   = ADDR_W'(MMIO_BASE + MMIO_SW);
  localparam logic [ADDR_W-1:0] A_CYC  = ADDR_W'(MMIO_BASE + MMIO_CYC);
  localparam logic [CNT_W-1:0]  CNT_LD = CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [DATA_W-1:0]  mmio_rd_q, mmio_rd_d;

  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  ram_rdata;
  logic               ram_we;
  logic               is_ram, is_led, is_sw, is_cyc, is_unmapped;

  // Address seen by the RAM and the MMIO read register: the live request
  // while idle (so a zero-wait access reads on its accept edge), the
  // latched one afterwards.
  assign cur_addr = (state_q == ST_IDLE) ? req_addr : addr_q;

  // Decode of the latched address, used for the response and the commit.
  assign is_ram      = (addr_q < A_BASE);
  assign is_led      = (addr_q == A_LED);
  assign is_sw       = (addr_q == A_SW);
  assign is_cyc      = (addr_q == A_CYC);
  assign is_unmapped = !(is_ram || is_led || is_sw || is_cyc);

  // Writes commit on the edge that ends RESP; a reset on that edge wins.
  assign ram_we = (state_q == ST_RESP) && we_q && is_ram && !rst;

  mem_resp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next state, request latch and LED write.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    led_d     = led_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            cnt_d   = CNT_LD;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
        if (we_q && is_led) led_d = wdata_q[LED_W-1:0];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MMIO read register tracks cur_addr every cycle, mirroring the RAM's
  // registered read so both paths are valid on entry to RESP.
  always_comb begin
    mmio_rd_d = '0;
    if (cur_addr == A_LED)      mmio_rd_d = DATA_W'(led_q);
    else if (cur_addr == A_SW)  mmio_rd_d = DATA_W'(sw_s2_q);
    else if (cur_addr == A_CYC) mmio_rd_d = DATA_W'(cyc_q);
  end

  // Response mux: data only for reads, errors for unmapped accesses and
  // writes to read-only registers.
  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state_q == ST_RESP) begin
      if (!we_q) rsp_rdata = is_ram ? ram_rdata : mmio_rd_q;
      rsp_err = is_unmapped || (we_q && (is_sw || is_cyc));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      led_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      cyc_q     <= '0;
      mmio_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      led_q     <= led_d;
      sw_s1_q   <= sw_in;
      sw_s2_q   <= sw_s1_q;
      cyc_q     <= cyc_q + 1'b1;
      mmio_rd_q <= mmio_rd_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          tb_cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // DUT with two wait states
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [9:0]  sw_in = '0, led_out;

  // DUT with zero wait states
  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [7:0]  z_addr = '0;
  logic [15:0] z_wdata = '0;
  logic        z_ready, z_rsp_valid, z_rsp_err;
  logic [15:0] z_rsp_rdata;
  logic [9:0]  z_sw_in = '0, z_led_out;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2), .MMIO_BASE('hF0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sw_in(sw_in), .led_out(led_out));

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0), .MMIO_BASE('hF0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_we(z_we),
    .req_addr(z_addr), .req_wdata(z_wdata), .req_ready(z_ready),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .sw_in(z_sw_in), .led_out(z_led_out));

  // One bus transaction on the two-wait DUT. lat counts cycles from the
  // accept edge to the rsp_valid cycle (-1 on timeout); acc is the bench
  // cycle number of the accept edge; rdy is req_ready during the response.
  task automatic bus(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic err, output int lat,
                     output int acc, output logic rdy);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 acc = tb_cyc;
    lat = -1; rd = 'x; err = 1'bx; rdy = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; err = rsp_err; rdy = req_ready;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
    checks++; if (led_out !== 10'h000) begin failures++; $display("FAIL reset_led got=%h exp=000", led_out); end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    // a request held during reset must not have been accepted
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_no_accept got=%b exp=1", req_ready); end
  endtask

  task automatic test_ram;
    logic [15:0] rd; logic err, rdy; int lat, acc;
    bus(1'b1, 8'h10, 16'hBEEF, rd, err, lat, acc, rdy);
    checks++; if (lat !== 3) begin failures++; $display("FAIL ram_wr_latency got=%0d exp=3", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ram_wr_err got=%b exp=0", err); end
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL ram_wr_rdata got=%h exp=0000", rd); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ram_wr_ready_in_resp got=%b exp=0", rdy); end
    bus(1'b0, 8'h10, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (lat !== 3) begin failures++; $display("FAIL ram_rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL ram_rd_data got=%h exp=BEEF", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ram_rd_err got=%b exp=0", err); end
    // neighbouring word keeps its own value
    bus(1'b1, 8'h11, 16'h1357, rd, err, lat, acc, rdy);
    bus(1'b0, 8'h10, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL ram_rd_neighbour got=%h exp=BEEF", rd); end
    bus(1'b0, 8'hEF, 16'h0000, rd, err, lat, acc, rdy);
    bus(1'b1, 8'hEF, 16'hA0A0, rd, err, lat, acc, rdy);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ram_top_wr_err got=%b exp=0", err); end
    bus(1'b0, 8'hEF, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'hA0A0) begin failures++; $display("FAIL ram_top_rd got=%h exp=A0A0", rd); end
  endtask

  task automatic test_zero_wait;
    logic        we_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ad_v [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    logic [15:0] wd_v [4] = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
    logic [15:0] ex_v [4] = '{16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A};
    int acc_prev, acc_now;
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      z_valid = 1'b1; z_we = we_v[i]; z_addr = ad_v[i]; z_wdata = wd_v[i];
      checks++; if (z_ready !== 1'b1) begin failures++; $display("FAIL zw_ready_idle[%0d] got=%b exp=1", i, z_ready); end
      @(posedge clk); #1 acc_now = tb_cyc;
      @(negedge clk);
      checks++; if (z_rsp_valid !== 1'b1) begin failures++; $display("FAIL zw_latency[%0d] rsp_valid got=%b exp=1", i, z_rsp_valid); end
      checks++; if (z_ready !== 1'b0) begin failures++; $display("FAIL zw_ready_resp[%0d] got=%b exp=0", i, z_ready); end
      checks++; if (z_rsp_rdata !== ex_v[i]) begin failures++; $display("FAIL zw_rdata[%0d] got=%h exp=%h", i, z_rsp_rdata, ex_v[i]); end
      if (i > 0) begin
        checks++; if (acc_now - acc_prev !== 2) begin failures++; $display("FAIL zw_spacing[%0d] got=%0d exp=2", i, acc_now - acc_prev); end
      end
      acc_prev = acc_now;
    end
    z_valid = 1'b0;
    @(negedge clk);
    checks++; if (z_rsp_valid !== 1'b0) begin failures++; $display("FAIL zw_single_pulse got=%b exp=0", z_rsp_valid); end
  endtask

  task automatic test_mmio;
    logic [15:0] rd; logic err, rdy; int lat, acc;
    bus(1'b1, 8'hF0, 16'h03FF, rd, err, lat, acc, rdy);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL led_wr_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (led_out !== 10'h3FF) begin failures++; $display("FAIL led_out got=%h exp=3FF", led_out); end
    bus(1'b0, 8'hF0, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'h03FF) begin failures++; $display("FAIL led_rd got=%h exp=03FF", rd); end
    sw_in = 10'h155;
    repeat (3) @(negedge clk);
    bus(1'b0, 8'hF1, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'h0155) begin failures++; $display("FAIL sw_rd got=%h exp=0155", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL sw_rd_err got=%b exp=0", err); end
  endtask

  task automatic test_errors;
    logic [15:0] rd; logic err, rdy; int lat, acc;
    bus(1'b1, 8'hF1, 16'hFFFF, rd, err, lat, acc, rdy);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sw_wr_err got=%b exp=1", err); end
    bus(1'b0, 8'hF1, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'h0155) begin failures++; $display("FAIL sw_after_wr got=%h exp=0155", rd); end
    bus(1'b0, 8'hF7, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL unmapped_rd got=%h exp=0000", rd); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL unmapped_rd_err got=%b exp=1", err); end
    bus(1'b1, 8'hF2, 16'h1111, rd, err, lat, acc, rdy);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL cyc_wr_err got=%b exp=1", err); end
    bus(1'b1, 8'hFF, 16'h2222, rd, err, lat, acc, rdy);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL unmapped_wr_err got=%b exp=1", err); end
    checks++; if (led_out !== 10'h3FF) begin failures++; $display("FAIL led_after_errs got=%h exp=3FF", led_out); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; logic err, rdy; int lat, acc;
    logic saw_rsp;
    bus(1'b1, 8'h20, 16'h0000, rd, err, lat, acc, rdy);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_in_wait ready got=%b exp=0", req_ready); end
    rst = 1'b1;
    saw_rsp = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
    checks++; if (saw_rsp !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got=%b exp=0", saw_rsp); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    checks++; if (led_out !== 10'h000) begin failures++; $display("FAIL mid_led_cleared got=%h exp=000", led_out); end
    bus(1'b0, 8'h20, 16'h0000, rd, err, lat, acc, rdy);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL mid_no_commit got=%h exp=0000", rd); end
  endtask

  task automatic test_cycle_counter;
    logic [15:0] v1, v2, v3, delta; logic err, rdy; int lat, a1, a2, a3, n;
    bus(1'b0, 8'hF2, 16'h0000, v1, err, lat, a1, rdy);
    repeat (5) @(negedge clk);
    bus(1'b0, 8'hF2, 16'h0000, v2, err, lat, a2, rdy);
    checks++; if (16'(v2 - v1) !== 16'(a2 - a1)) begin failures++; $display("FAIL cyc_diff got=%0d exp=%0d", 16'(v2 - v1), 16'(a2 - a1)); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cyc_rd_err got=%b exp=0", err); end
    // space the next accept so the counter wraps and reads back as 2
    delta = 16'h0002 - v2;
    n = int'(delta) - 4;
    if (n < 0) n += 65536;
    repeat (n) @(negedge clk);
    bus(1'b0, 8'hF2, 16'h0000, v3, err, lat, a3, rdy);
    checks++; if (v3 !== 16'h0002) begin failures++; $display("FAIL cyc_wrap got=%h exp=0002 (spacing %0d)", v3, a3 - a2); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_zero_wait;
    test_mmio;
    test_errors;
    test_reset_mid;
    test_cycle_counter;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit CPU's data/instruction bus. Accepts one read or write request at a time from the CPU controller, inserts a programmable number of wait states, then returns a one-cycle response. It backs a 240-word RAM plus a small memory-mapped I/O window (LEDs, switches, cycle counter), and replaces the zero-latency RAM at the bottom of the CPU top level.

## Interface
- `ADDR_W`, 8: request address width.
- `DATA_W`, 16: data word width.
- `WAIT_CYCLES`, 2: wait states between accept and response; legal range 0–15.
- `MMIO_BASE`, 8'hF0: first MMIO address; RAM occupies 0 to MMIO_BASE-1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: request present.
- `req_we`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, ADDR_W: word address.
- `req_wdata`, input, DATA_W: write data.
- `req_ready`, output, 1: responder can accept a request this cycle.
- `rsp_valid`, output, 1: one-cycle pulse marking completion of the accepted request.
- `rsp_rdata`, output, DATA_W: read data, valid while `rsp_valid` is high; 0 for writes.
- `rsp_err`, output, 1: access error, valid with `rsp_valid`.
- `sw_in`, input, 10: asynchronous switch inputs.
- `led_out`, output, 10: LED register.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `req_we`, `req_addr` and `req_wdata`.
  - If WAIT_CYCLES > 0: load the wait counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES = 0: go directly to RESP.
- **WAIT**
  - `req_ready` = 0.
  - The counter decrements each cycle; go to RESP when the counter reaches 0.
  - Request inputs are ignored.
- **RESP**
  - `req_ready` = 0 and `rsp_valid` = 1, for exactly one cycle.
  - A write commits at the clock edge that ends RESP.
  - Always return to IDLE; back-to-back requests therefore cost one IDLE cycle each.
- **Address map** (the latched address is decoded in WAIT/RESP):
  - 0x00 to MMIO_BASE-1: RAM, read/write.
  - MMIO_BASE+0: LED register, read/write. Writes take `wdata[9:0]`. Reads return `{6'b0, led}`.
  - MMIO_BASE+1: switches, read-only. Returns `{6'b0, sw_sync}`, where `sw_sync` is `sw_in` passed through a two-flop synchronizer.
  - MMIO_BASE+2: cycle counter, read-only. 16-bit, free-running, increments every cycle and wraps from 0xFFFF to 0.
  - MMIO_BASE+3 to 0xFF: unmapped. Reads return 0.
- **Errors:**
  - A write to a read-only or unmapped address is dropped with `rsp_err` = 1.
  - A read of an unmapped address sets `rsp_err` = 1.
  - All other accesses give `rsp_err` = 0.
- **Read data:** the RAM is read synchronously on entry to RESP, with the address presented on the last WAIT or accept cycle. `rsp_rdata` comes from a registered output.

## Timing
- A request accepted at edge T produces `rsp_valid` high during cycle T+WAIT_CYCLES+1.
- The next accept can occur at T+WAIT_CYCLES+2 at the earliest.
- With WAIT_CYCLES = 0, latency is 1 cycle.
- Written data is visible to a subsequent read of the same address with no hazard, since accesses are serialized.
- Values in reset:
  - state = IDLE, wait counter = 0;
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0;
  - `led_out` = 0, cycle counter = 0, synchronizer flops = 0.
  - RAM contents are not reset.
- Reset asserted in WAIT or RESP aborts the request. A pending write is not committed, and no `rsp_valid` is produced.
- A `req_valid` coincident with `rst` is not accepted.
- The cycle counter has no overflow flag.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - MMIO offset constants (LED = 0, SW = 1, CYC = 2);
  - the widths LED_W = 10 and SW_W = 10.
- Sub-module `mem_resp_ram` is a single-port synchronous array of 2^ADDR_W words by DATA_W bits. It has `clk`, `we`, `addr`, `wdata` and `rdata` ports, and its write enable is gated to RAM addresses only.
- The FSM, wait counter, MMIO registers, synchronizer and response mux live in `mem_responder`.

## Test plan
- **RAM write then read:** with WAIT_CYCLES = 2, write 16'hBEEF to 0x10, then read 0x10.
  - Required: `rsp_valid` 3 cycles after each accept, read `rsp_rdata` = 16'hBEEF, `rsp_err` = 0.
- **Zero wait:** with WAIT_CYCLES = 0, issue back-to-back reads of 0x00 and 0x01.
  - Required: `rsp_valid` 1 cycle after each accept, `req_ready` low in RESP, accepts spaced 2 cycles apart.
- **MMIO:**
  - Write 16'h03FF to 0xF0: `led_out` = 10'h3FF.
  - Read 0xF0: returns 16'h03FF.
  - Drive `sw_in` = 10'h155 and wait ≥ 2 cycles, then read 0xF1: returns 16'h0155.
- **Errors:**
  - Write to 0xF1: `rsp_err` = 1, switch read unchanged.
  - Read 0xF7: `rsp_rdata` = 0, `rsp_err` = 1.
- **Reset mid-operation:** write 16'h1234 to 0x20, then assert `rst` in WAIT.
  - Required: no `rsp_valid`, `req_ready` = 1 after reset, and a later read of 0x20 does not return 16'h1234 (location pre-loaded to 0).
- **Cycle counter:** read 0xF2 twice with a known request spacing.
  - Required: the difference equals the elapsed cycles.
  - Also force wrap past 0xFFFF and check it returns to 0.
